// File: rtl/harris_tile_sched_if.sv
// ---------------------------------------------------------------------------
// harris_tile_sched_if
//
// Purpose : bundles the window-fetch handshake and the gradient datapath
//           strobes/coordinates of the Harris tile scheduler.
//
// Signals :
//   fetch_req   scheduler -> memory   request to load a 6x6 window
//   fetch_row   scheduler -> memory   window top-left row
//   fetch_col   scheduler -> memory   window top-left column
//   fetch_ack   memory -> scheduler   window loaded and stable
//   sink_ready  sink -> scheduler     result can be captured LAT cycles later
//   win_valid   scheduler -> datapath one-cycle window strobe
//   out_valid   scheduler -> sink     gradient result valid
//   out_row     scheduler -> sink     tile row matching out_valid
//   out_col     scheduler -> sink     tile column matching out_valid
//
// Modports: master = scheduler side, slave = memory/datapath/sink side.
// ---------------------------------------------------------------------------
interface harris_tile_sched_if #(
    parameter int CW = 8
) ();
    logic          fetch_req;
    logic [CW-1:0] fetch_row;
    logic [CW-1:0] fetch_col;
    logic          fetch_ack;
    logic          sink_ready;
    logic          win_valid;
    logic          out_valid;
    logic [CW-1:0] out_row;
    logic [CW-1:0] out_col;

    modport master (
        output fetch_req, fetch_row, fetch_col,
        output win_valid, out_valid, out_row, out_col,
        input  fetch_ack, sink_ready
    );

    modport slave (
        input  fetch_req, fetch_row, fetch_col,
        input  win_valid, out_valid, out_row, out_col,
        output fetch_ack, sink_ready
    );
endinterface

// File: rtl/harris_tile_sched.sv
// ---------------------------------------------------------------------------
// harris_tile_sched
//
// Purpose : walks an IMG_W x IMG_H image in 6x6 windows on a stride of 4
//           (raster order, columns fastest). For each tile it requests the
//           window, waits for the load, issues one strobe to the gradient
//           pipeline when the sink is ready, and reports the result LAT cycles
//           later together with the tile coordinate.
//
// Ports :
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   start     frame start pulse, honoured only when idle
//   abort     synchronous frame abort (highest priority)
//   bus       harris_tile_sched_if.master (fetch handshake, strobes, coords)
//   busy      high whenever the scheduler is not idle
//   done      one-cycle end-of-frame pulse
//   tile_cnt  tiles completed in the current frame
//
// Timing : every output is a flop. win_valid appears in the first DRAIN cycle
//          (the cycle after ISSUE saw sink_ready); DRAIN lasts LAT cycles and
//          out_valid is registered out of its final cycle, so out_valid lands
//          exactly LAT cycles after win_valid. tile_cnt and the next fetch
//          request become visible in the same cycle as out_valid.
//
// Parameters must satisfy IMG_W >= 6, IMG_H >= 6, LAT >= 1.
// ---------------------------------------------------------------------------
module harris_tile_sched #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int LAT   = 1,
    parameter int CW    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    harris_tile_sched_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          tile_cnt
);

    // Coordinates of the last tile in each direction (stride 4).
    localparam int COL_LAST = ((IMG_W - 6) / 4) * 4;
    localparam int ROW_LAST = ((IMG_H - 6) / 4) * 4;
    localparam int LW       = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] row_reg, row_next;
    logic [CW-1:0] col_reg, col_next;
    logic [LW-1:0] lat_reg, lat_next;
    logic [15:0]   tile_cnt_reg, tile_cnt_next;
    logic          fetch_req_reg, fetch_req_next;
    logic          win_valid_reg, win_valid_next;
    logic          out_valid_reg, out_valid_next;
    logic [CW-1:0] out_row_reg, out_row_next;
    logic [CW-1:0] out_col_reg, out_col_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;

    logic          last_col;
    logic          last_tile;

    assign last_col  = (col_reg == CW'(COL_LAST));
    assign last_tile = last_col && (row_reg == CW'(ROW_LAST));

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            row_reg       <= '0;
            col_reg       <= '0;
            lat_reg       <= '0;
            tile_cnt_reg  <= '0;
            fetch_req_reg <= 1'b0;
            win_valid_reg <= 1'b0;
            out_valid_reg <= 1'b0;
            out_row_reg   <= '0;
            out_col_reg   <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            row_reg       <= row_next;
            col_reg       <= col_next;
            lat_reg       <= lat_next;
            tile_cnt_reg  <= tile_cnt_next;
            fetch_req_reg <= fetch_req_next;
            win_valid_reg <= win_valid_next;
            out_valid_reg <= out_valid_next;
            out_row_reg   <= out_row_next;
            out_col_reg   <= out_col_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        row_next       = row_reg;
        col_next       = col_reg;
        lat_next       = lat_reg;
        tile_cnt_next  = tile_cnt_reg;
        win_valid_next = 1'b0;
        out_valid_next = 1'b0;
        out_row_next   = out_row_reg;
        out_col_next   = out_col_reg;
        done_next      = 1'b0;

        if (abort) begin
            // Abort wins over everything else; the frame is dropped silently.
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_next    = FETCH;
                        row_next      = '0;
                        col_next      = '0;
                        tile_cnt_next = '0;
                    end
                end
                FETCH: begin
                    if (bus.fetch_ack) begin
                        state_next = ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.sink_ready) begin
                        state_next     = DRAIN;
                        win_valid_next = 1'b1;
                        lat_next       = '0;
                    end
                end
                DRAIN: begin
                    if (lat_reg == LW'(LAT - 1)) begin
                        out_valid_next = 1'b1;
                        out_row_next   = row_reg;
                        out_col_next   = col_reg;
                        tile_cnt_next  = tile_cnt_reg + 16'd1;
                        if (last_tile) begin
                            state_next = DONE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = FETCH;
                            if (last_col) begin
                                col_next = '0;
                                row_next = row_reg + CW'(4);
                            end else begin
                                col_next = col_reg + CW'(4);
                            end
                        end
                    end else begin
                        lat_next = lat_reg + LW'(1);
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        // Level outputs follow the state being entered so they are flops.
        fetch_req_next = (state_next == FETCH);
        busy_next      = (state_next != IDLE);
    end

    assign bus.fetch_req = fetch_req_reg;
    assign bus.fetch_row = row_reg;
    assign bus.fetch_col = col_reg;
    assign bus.win_valid = win_valid_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_row   = out_row_reg;
    assign bus.out_col   = out_col_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign tile_cnt      = tile_cnt_reg;

endmodule
